fa_acc_seq: RTL
===============

Name: fa_acc_seq

Overview:
- Sequencing initiator for the single-precision adder `fa` in the fully-connected datapath. It sums a stream of N FP32 terms into one FP32 result, such as partial products of a neuron.
- It accepts terms over a valid/ready stream and issues one add at a time to an external `fa` instance over its `v`/`valid` interface.
- It returns the final sum with a one-cycle result strobe.

Parameters:
- N, 8, number of FP32 terms per accumulation; legal range 1..2^CNT_W-1.
- CNT_W, 4, width of the term counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new accumulation; sampled only in IDLE.
- in_data  input  32  FP32 term.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- fa_a  output  32  adder operand a (running accumulator).
- fa_b  output  32  adder operand b (new term).
- fa_v  output  1  adder activation; pulse is exactly 1 cycle.
- fa_sum  input  32  adder sum.
- fa_valid  input  1  adder completion strobe.
- result  output  32  final FP32 sum; held until next completion.
- result_valid  output  1  one-cycle strobe, result is valid.
- busy  output  1  high from start acceptance until result_valid.

Behaviour:
- **Registers:** all outputs except in_ready are registered. in_ready is a combinational decode of state.
- **Reset (rst=1 at edge):**
  - state <= IDLE; acc, cnt, fa_a, fa_b, result <= 0.
  - fa_v, result_valid, busy <= 0.
  - in_ready is 0 in IDLE.
- **States:** IDLE, FIRST, NEXT, WAIT.
- **IDLE:**
  - in_ready=0.
  - start=1 -> FIRST, busy<=1, cnt<=0.
  - fa_valid is ignored.
- **FIRST:**
  - in_ready=1.
  - On in_valid&in_ready: acc<=in_data, cnt<=1.
  - The first term is loaded directly, never added to 0.0, because `fa` forces the hidden bit and mis-handles zero operands.
  - If N==1: result<=in_data, result_valid<=1, busy<=0, -> IDLE. Otherwise -> NEXT.
- **NEXT:**
  - in_ready=1.
  - On handshake: fa_a<=acc, fa_b<=in_data, fa_v<=1, -> WAIT.
  - Without handshake: stay; in_valid gaps of any length are allowed.
- **WAIT:**
  - in_ready=0; fa_v<=0 on the first WAIT edge, so the pulse width is 1.
  - On fa_valid=1: acc<=fa_sum, cnt<=cnt+1.
  - If cnt+1==N: result<=fa_sum, result_valid<=1, busy<=0, -> IDLE. Otherwise -> NEXT.
  - fa_a/fa_b stay stable through WAIT.
- **Latency:**
  - `fa` registers valid one edge after sampling v, so each add occupies 3 cycles (NEXT, WAIT with fa_v high, WAIT with fa_valid high).
  - With in_valid held high, result_valid is set at edge 3N-2 after the start edge. Example: N=4 gives edge 10.
- **Strobes and ignored events:**
  - result_valid is high exactly 1 cycle.
  - start is ignored while busy, including on the completion edge.
  - start may be accepted the cycle after result_valid.
  - fa_valid outside WAIT is ignored.
- **Overflow:** cnt never exceeds N; no wrap.
- **Reset mid-operation:** partial acc is discarded and fa_v=0 after the reset edge. A stale fa_valid arriving after reset is ignored (state is IDLE).
- **Arithmetic:** all arithmetic is done by `fa`. This block performs no FP manipulation and passes fa_sum through bit-exact.

Test Plan:
- N=4, in_valid held high, start at edge 0, terms 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (1,2,3,4) -> three fa_v pulses of width 1; result=0x41200000 (10.0); result_valid high only after edge 10; busy low after that edge.
- N=4, terms 0x41000000, 0xC0000000, 0x3F000000, 0x3E800000 (8,-2,0.5,0.25) -> result=0x40D80000 (6.75); fa_a on the third add = 0x40D00000.
- N=1, term 0xC0A00000 -> fa_v never asserted; result=0xC0A00000; result_valid set at edge 1.
- N=4, in_valid deasserted for 5 cycles before terms 2 and 4 -> in_ready stays high in NEXT; fa_a/fa_b stable through each WAIT; result=0x41200000.
- Assert rst during WAIT of the second add, then inject fa_valid one cycle later -> state IDLE; result_valid stays 0; busy=0. A fresh run then yields 0x41200000.
- Pulse start during NEXT, and fa_valid while in IDLE -> no state change, no extra fa_v, cnt unaffected.

Source files
------------

// File: rtl/fa_acc_seq.sv
// fa_acc_seq: sums a stream of N FP32 terms by sequencing one add at a time
// through an external single-precision adder (fa) over its v/valid handshake.
// The first term is loaded straight into the accumulator. fa mis-handles zero
// operands, so the sum never starts from 0.0. fa_sum is passed through bit-exact.
module fa_acc_seq #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] fa_a,
  output logic [31:0] fa_b,
  output logic        fa_v,
  input  logic [31:0] fa_sum,
  input  logic        fa_valid,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam logic [CNT_W-1:0] N_C   = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_NEXT  = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   fa_a_q, fa_a_d;
  logic [DATA_W-1:0]   fa_b_q, fa_b_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                fa_v_q, fa_v_d;
  logic                rv_q, rv_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_inc;

  // cnt never exceeds N, and N fits in CNT_W, so this increment cannot wrap
  assign cnt_inc = cnt_q + ONE_C;

  // Next-state and output decode; strobes default low so they last one cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    fa_a_d   = fa_a_q;
    fa_b_d   = fa_b_q;
    result_d = result_q;
    fa_v_d   = 1'b0;
    rv_d     = 1'b0;
    busy_d   = busy_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FIRST;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_FIRST: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = in_data;
          cnt_d = ONE_C;
          if (N == 1) begin
            result_d = in_data;
            rv_d     = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fa_a_d  = acc_q;
          fa_b_d  = in_data;
          fa_v_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // fa_a/fa_b hold their values here; fa_v drops on the first WAIT edge
        if (fa_valid) begin
          acc_d = fa_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == N_C) begin
            result_d = fa_sum;
            rv_d     = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      fa_a_q   <= '0;
      fa_b_q   <= '0;
      result_q <= '0;
      fa_v_q   <= 1'b0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      fa_a_q   <= fa_a_d;
      fa_b_q   <= fa_b_d;
      result_q <= result_d;
      fa_v_q   <= fa_v_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
    end
  end

  assign fa_a         = fa_a_q;
  assign fa_b         = fa_b_q;
  assign fa_v         = fa_v_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;

endmodule
